ghost_mode_sched: RTL
=====================

GHOST_MODE_SCHED -- requirements
Module: ghost_mode_sched

Interface
- REQ-001 SHALL have parameter TICK_HZ, default 24, meaning the rate of `tick_24hz` pulses.
- REQ-002 SHALL have parameter FRIGHT_TICKS, default 144, meaning frightened duration (6 s).
- REQ-003 SHALL have parameter FLASH_TICKS, default 48, meaning flashing window at the end of frightened (2 s).
- REQ-004 clk_50mhz  in  1  sole clock; all logic is on its rising edge.
- REQ-005 reset  in  1  asynchronous, active-high reset.
- REQ-006 tick_24hz  in  1  one-cycle pulse; time base for all timers.
- REQ-007 level_start  in  1  one-cycle pulse; restarts the schedule at phase 0.
- REQ-008 power_pellet  in  1  one-cycle pulse; Pac-Man ate an energizer.
- REQ-009 pacman_dead  in  1  level signal; freezes all timers while high.
- REQ-010 ghost_mode_bits  out  2  mode: 00 chase, 01 scatter, 10 frightened, 11 frightened-flash.
- REQ-011 ghost_reverse  out  1  one-cycle pulse; ghosts must reverse direction.
- REQ-012 phase_idx  out  3  current schedule phase 0..7.

Function
- REQ-013 Schedule phases 0..7 SHALL be scatter 168, chase 480, scatter 168, chase 480, scatter 120, chase 480, scatter 120, chase infinite (ticks).
- REQ-014 The FSM SHALL have two states: SCHED (mode from phase_idx: even = scatter, odd = chase) and FRIGHT.
- REQ-015 In SCHED, each tick SHALL decrement the 10-bit phase counter. A tick seen at count 1 SHALL advance phase_idx, load the next duration and assert ghost_reverse in the same cycle.
- REQ-016 In phase 7 the counter SHALL not decrement, and phase_idx SHALL saturate at 7.
- REQ-017 power_pellet in SCHED SHALL enter FRIGHT, load the 8-bit fright counter with FRIGHT_TICKS, assert ghost_reverse and hold the phase counter.
- REQ-018 power_pellet in FRIGHT SHALL reload FRIGHT_TICKS and SHALL NOT pulse ghost_reverse.
- REQ-019 In FRIGHT, each tick SHALL decrement the fright counter. The mode SHALL be 11 while the counter is <= FLASH_TICKS and 10 otherwise.
- REQ-020 A tick at fright count 1 SHALL return the FSM to SCHED with the phase counter resumed unchanged and no reverse pulse.
- REQ-021 Priority SHALL be reset > level_start > pacman_dead > power_pellet > tick_24hz.
- REQ-022 When power_pellet coincides with a phase-expiry tick, the pellet SHALL win and the tick SHALL be discarded (the phase counter does not change).
- REQ-023 While pacman_dead is high, tick_24hz and power_pellet SHALL be ignored and all outputs held.
- REQ-024 level_start SHALL force SCHED, phase 0, count 168 and fright count 0, with no reverse pulse.
- REQ-025 All outputs SHALL be registered, with 1-cycle latency from the input pulse to the output change.

Reset
- REQ-026 Reset SHALL set the state to SCHED, phase_idx to 0, the phase counter to 168, the fright counter to 0, ghost_mode_bits to 01 and ghost_reverse to 0.
- REQ-027 Reset asserted mid-FRIGHT SHALL abandon the fright mode immediately and apply the values in REQ-026.

Structure
- REQ-028 The mode encodings, the phase duration table and the FSM state codes SHALL live in the shared constants include `ghost_defs`, used by the ghost_mode and pacman_death consumers.
- REQ-029 One sub-module `tick_down_counter` (parameterised width, load, tick-enable decrement, hold, expiry flag) SHALL be instantiated twice, once for the phase counter and once for the fright counter.

Verification
- REQ-030 After reset, apply 168 ticks. On the cycle after the 168th tick, ghost_mode_bits SHALL go 01->00, phase_idx SHALL be 1 and ghost_reverse SHALL pulse for 1 cycle.
- REQ-031 Pellet at phase 1 with 100 ticks left, then 144 ticks:
  - mode SHALL be 10 for 96 ticks, then 11 for 48 ticks;
  - mode SHALL then return to 00 with 100 ticks still left in phase 1;
  - ghost_reverse SHALL pulse only once, at pellet entry.
- REQ-032 Second pellet after 120 fright ticks: the fright counter SHALL reload to 144, mode SHALL go 11->10, and there SHALL be no reverse pulse.
- REQ-033 Run all phases: phase_idx SHALL stick at 7 with mode 00 after 1000 further ticks.
- REQ-034 Hold pacman_dead high for 50 ticks plus a pellet: outputs SHALL be unchanged. Then pulse level_start: phase 0, mode 01, no reverse.
- REQ-035 Pellet and expiry tick in the same cycle: FRIGHT SHALL be entered, phase_idx unchanged, phase count still 1.

Source files
------------

// File: rtl/ghost_mode_sched_pkg.sv
// Shared ghost-scheduler constants: mode encodings, FSM state codes and the
// per-phase scatter/chase duration table.
`timescale 1ns/1ps
package ghost_mode_sched_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE   = 2'b00,
    MODE_SCATTER = 2'b01,
    MODE_FRIGHT  = 2'b10,
    MODE_FLASH   = 2'b11
  } ghost_mode_t;

  typedef enum logic {
    ST_SCHED  = 1'b0,
    ST_FRIGHT = 1'b1
  } sched_state_t;

  localparam int PHASE_W  = 10;
  localparam int FRIGHT_W = 8;
  localparam int IDX_W    = 3;

  localparam logic [IDX_W-1:0]   LAST_PHASE   = 3'd7;
  localparam logic [PHASE_W-1:0] PHASE0_TICKS = 10'd168;

  // The final chase phase never expires, so its table entry is never counted down.
  function automatic logic [PHASE_W-1:0] phase_duration(input logic [IDX_W-1:0] idx);
    logic [PHASE_W-1:0] ticks;
    case (idx)
      3'd0:    ticks = 10'd168;
      3'd1:    ticks = 10'd480;
      3'd2:    ticks = 10'd168;
      3'd3:    ticks = 10'd480;
      3'd4:    ticks = 10'd120;
      3'd5:    ticks = 10'd480;
      3'd6:    ticks = 10'd120;
      default: ticks = 10'd0;
    endcase
    return ticks;
  endfunction

  function automatic ghost_mode_t sched_mode(input logic [IDX_W-1:0] idx);
    return idx[0] ? MODE_CHASE : MODE_SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_sched_tick_down_counter.sv
// Loadable down-counter that decrements on an enable and stops at zero;
// flags the cycle in which the count sits at one.
`timescale 1ns/1ps
module tick_down_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             expiring
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Load beats decrement; the exposed next value lets the parent register
  // outputs that depend on where the counter is about to land.
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_value;
    end else if (dec && (count != '0)) begin
      next_count = count - ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else begin
      count <= next_count;
    end
  end

  assign expiring = (count == ONE);

endmodule

// File: rtl/ghost_mode_sched.sv
// Ghost scatter/chase/frightened mode scheduler driven by a 24 Hz tick.
`timescale 1ns/1ps
module ghost_mode_sched
  import ghost_mode_sched_pkg::*;
#(
  parameter int TICK_HZ      = 24,
  parameter int FRIGHT_TICKS = 144,
  parameter int FLASH_TICKS  = 48
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       tick_24hz,
  input  logic       level_start,
  input  logic       power_pellet,
  input  logic       pacman_dead,
  output logic [1:0] ghost_mode_bits,
  output logic       ghost_reverse,
  output logic [2:0] phase_idx
);

  localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD = FRIGHT_W'(FRIGHT_TICKS);
  localparam logic [FRIGHT_W-1:0] FLASH_LOAD  = FRIGHT_W'(FLASH_TICKS);

  if (TICK_HZ < 1 || FRIGHT_TICKS > 255 || FRIGHT_TICKS < 1 || FLASH_TICKS > FRIGHT_TICKS)
  begin : g_param_check
    $error("ghost_mode_sched: inconsistent timer parameters");
  end

  sched_state_t       state, state_next;
  ghost_mode_t        mode_q, mode_next;
  logic [IDX_W-1:0]   phase_next;
  logic               reverse_next;

  logic               phase_load, phase_dec, phase_expiring;
  logic [PHASE_W-1:0] phase_load_value, phase_count, phase_count_next;
  logic               fright_load, fright_dec, fright_expiring;
  logic [FRIGHT_W-1:0] fright_load_value, fright_count, fright_count_next;

  tick_down_counter #(
    .WIDTH       (PHASE_W),
    .RESET_VALUE (PHASE0_TICKS)
  ) u_phase_counter (
    .clk        (clk_50mhz),
    .reset      (reset),
    .load       (phase_load),
    .load_value (phase_load_value),
    .dec        (phase_dec),
    .count      (phase_count),
    .next_count (phase_count_next),
    .expiring   (phase_expiring)
  );

  tick_down_counter #(
    .WIDTH       (FRIGHT_W),
    .RESET_VALUE ('0)
  ) u_fright_counter (
    .clk        (clk_50mhz),
    .reset      (reset),
    .load       (fright_load),
    .load_value (fright_load_value),
    .dec        (fright_dec),
    .count      (fright_count),
    .next_count (fright_count_next),
    .expiring   (fright_expiring)
  );

  // Priority: level_start, then pacman_dead (freeze), then power_pellet, then tick.
  // A pellet arriving with an expiry tick takes the tick's slot, leaving the phase
  // counter parked at one so the phase ends on the first tick after fright.
  always_comb begin
    state_next        = state;
    phase_next        = phase_idx;
    reverse_next      = 1'b0;
    phase_load        = 1'b0;
    phase_load_value  = PHASE0_TICKS;
    phase_dec         = 1'b0;
    fright_load       = 1'b0;
    fright_load_value = FRIGHT_LOAD;
    fright_dec        = 1'b0;
    mode_next         = mode_q;

    if (level_start) begin
      state_next        = ST_SCHED;
      phase_next        = '0;
      phase_load        = 1'b1;
      phase_load_value  = PHASE0_TICKS;
      fright_load       = 1'b1;
      fright_load_value = '0;
    end else if (!pacman_dead) begin
      if (power_pellet) begin
        fright_load = 1'b1;
        if (state == ST_SCHED) begin
          state_next   = ST_FRIGHT;
          reverse_next = 1'b1;
        end
      end else if (tick_24hz) begin
        if (state == ST_FRIGHT) begin
          fright_dec = 1'b1;
          if (fright_expiring) begin
            state_next = ST_SCHED;
          end
        end else if (phase_idx != LAST_PHASE) begin
          if (phase_expiring) begin
            phase_next       = phase_idx + 3'd1;
            phase_load       = 1'b1;
            phase_load_value = phase_duration(phase_idx + 3'd1);
            reverse_next     = 1'b1;
          end else begin
            phase_dec = 1'b1;
          end
        end
      end
    end

    if (state_next == ST_FRIGHT) begin
      mode_next = (fright_count_next <= FLASH_LOAD) ? MODE_FLASH : MODE_FRIGHT;
    end else begin
      mode_next = sched_mode(phase_next);
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state         <= ST_SCHED;
      phase_idx     <= '0;
      mode_q        <= MODE_SCATTER;
      ghost_reverse <= 1'b0;
    end else begin
      state         <= state_next;
      phase_idx     <= phase_next;
      mode_q        <= mode_next;
      ghost_reverse <= reverse_next;
    end
  end

  assign ghost_mode_bits = mode_q;

endmodule
